// File: rtl/timer_ctrl.sv
// timer_ctrl: sequences game rounds over the timer start/timesup handshake.
// Build option: define TIMER_CTRL_WDOG_EN to add the RUN-state watchdog.
module timer_ctrl #(
  parameter int ROUNDS      = 3,
  parameter int TARGET      = 10,
  parameter int HIT_W       = 4,
  parameter int WDOG_CYCLES = 64,
  localparam int RW = (ROUNDS > 1) ? $clog2(ROUNDS) : 1,
  localparam int SW = $clog2(ROUNDS + 1)
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             go,
  input  logic             abort,
  input  logic             hit,
  input  logic             timesup,
  output logic             start_timer,
  output logic             busy,
  output logic [RW-1:0]    round_idx,
  output logic [HIT_W-1:0] hit_cnt,
  output logic [SW-1:0]    score,
  output logic             round_done,
  output logic             round_win,
  output logic             all_done,
  output logic             wdog_err
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ARM,
    S_RUN,
    S_REL,
    S_DONE
  } state_t;

  state_t           state_q;
  state_t           state_d;
  logic [HIT_W-1:0] hit_d;
  logic [HIT_W-1:0] hit_inc;
  logic [RW-1:0]    ridx_d;
  logic [SW-1:0]    score_d;
  logic             win_d;
  logic             done_d;
  logic             hit_last;
  logic             wdog_hit;

  assign hit_inc  = hit_cnt + HIT_W'(hit);
  assign hit_last = hit && (hit_cnt == HIT_W'(TARGET - 1));

  // Next state and next values of the round bookkeeping.
  always_comb begin
    state_d = state_q;
    hit_d   = hit_cnt;
    ridx_d  = round_idx;
    score_d = score;
    win_d   = round_win;
    done_d  = 1'b0;
    unique case (state_q)
      S_IDLE, S_DONE: begin
        if (go) begin
          state_d = S_ARM;
          hit_d   = '0;
          ridx_d  = '0;
          score_d = '0;
          win_d   = 1'b0;
        end
      end
      S_ARM: begin
        if (!timesup) state_d = S_RUN;
      end
      S_RUN: begin
        hit_d = hit_inc;
        if (hit_last) begin
          state_d = S_REL;
          win_d   = 1'b1;
          score_d = score + SW'(1);
          done_d  = 1'b1;
        end else if (timesup || wdog_hit) begin
          state_d = S_REL;
          win_d   = 1'b0;
          done_d  = 1'b1;
        end
      end
      S_REL: begin
        if (!timesup) begin
          if (round_idx == RW'(ROUNDS - 1)) begin
            state_d = S_DONE;
          end else begin
            state_d = S_ARM;
            ridx_d  = round_idx + RW'(1);
            hit_d   = '0;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
    if (abort) begin
      state_d = S_IDLE;
      hit_d   = '0;
      ridx_d  = '0;
      score_d = '0;
      win_d   = 1'b0;
      done_d  = 1'b0;
    end
  end

  // State and registered outputs, decoded from the next state.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= S_IDLE;
      hit_cnt     <= '0;
      round_idx   <= '0;
      score       <= '0;
      round_win   <= 1'b0;
      round_done  <= 1'b0;
      start_timer <= 1'b0;
      busy        <= 1'b0;
      all_done    <= 1'b0;
    end else begin
      state_q     <= state_d;
      hit_cnt     <= hit_d;
      round_idx   <= ridx_d;
      score       <= score_d;
      round_win   <= win_d;
      round_done  <= done_d;
      start_timer <= (state_d == S_RUN);
      busy        <= (state_d == S_ARM) ||
                     (state_d == S_RUN) ||
                     (state_d == S_REL);
      all_done    <= (state_d == S_DONE);
    end
  end

`ifdef TIMER_CTRL_WDOG_EN
  localparam int CW = $clog2(WDOG_CYCLES + 1);

  logic [CW-1:0] wcnt_q;
  logic          werr_q;
  logic          restart;

  assign wdog_hit = (wcnt_q == CW'(WDOG_CYCLES - 1));
  assign restart  = go && (state_q == S_IDLE ||
                           state_q == S_DONE);
  assign wdog_err = werr_q;

  // RUN-cycle counter; held at zero outside RUN so each round starts fresh.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      wcnt_q <= '0;
    end else if (state_q != S_RUN) begin
      wcnt_q <= '0;
    end else begin
      wcnt_q <= wcnt_q + CW'(1);
    end
  end

  // Sticky flag: set when the watchdog, not timesup or a win, ends a round.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      werr_q <= 1'b0;
    end else if (abort || restart) begin
      werr_q <= 1'b0;
    end else if (state_q == S_RUN && wdog_hit &&
                 !timesup && !hit_last) begin
      werr_q <= 1'b1;
    end
  end
`else
  assign wdog_hit = 1'b0;
  assign wdog_err = 1'b0;
`endif

endmodule

// File: tb/tb_timer_ctrl.sv
// tb_timer_ctrl: randomized rounds against a per-round outcome model;
// expected round/game results are queued and checked by a monitor.
module tb_timer_ctrl;

  localparam int ROUNDS = 3;
  localparam int TARGET = 10;
  localparam int HIT_W  = 4;
  localparam int WDOG   = 64;

  logic             clock = 1'b0;
  logic             reset_n = 1'b0;
  logic             go = 1'b0;
  logic             abort = 1'b0;
  logic             hit = 1'b0;
  logic             timesup = 1'b0;
  logic             start_timer;
  logic             busy;
  logic [1:0]       round_idx;
  logic [HIT_W-1:0] hit_cnt;
  logic [1:0]       score;
  logic             round_done;
  logic             round_win;
  logic             all_done;
  logic             wdog_err;

  typedef struct {
    bit game;
    bit win;
    int score;
    int hits;
    int idx;
    bit werr;
    int due;
  } exp_t;

  exp_t q[$];
  exp_t m;
  int   total = 0;
  int   bad = 0;
  int   cyc = 0;
  int   exp_score = 0;
  bit   exp_werr = 1'b0;
  logic prev_done = 1'b0;

  timer_ctrl #(
    .ROUNDS(ROUNDS),
    .TARGET(TARGET),
    .HIT_W(HIT_W),
    .WDOG_CYCLES(WDOG)
  ) dut (
    .clock(clock),
    .reset_n(reset_n),
    .go(go),
    .abort(abort),
    .hit(hit),
    .timesup(timesup),
    .start_timer(start_timer),
    .busy(busy),
    .round_idx(round_idx),
    .hit_cnt(hit_cnt),
    .score(score),
    .round_done(round_done),
    .round_win(round_win),
    .all_done(all_done),
    .wdog_err(wdog_err)
  );

  always #5 clock = ~clock;

  always @(posedge clock) cyc <= cyc + 1;

  initial begin
    #500000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1);
  end

  task automatic chk(input string name, input int act, input int req);
    total++;
    if (act != req) begin
      bad++;
      $display("FAIL %s: got %0d want %0d (cyc %0d)",
               name, act, req, cyc);
    end
  endtask

  function automatic bit rb();
    return 1'($urandom_range(0, 1));
  endfunction

  function automatic bit rgo();
    return ($urandom_range(0, 15) == 0);
  endfunction

  task automatic step(input bit h, input bit t,
                      input bit g, input bit a);
    hit = h;
    timesup = t;
    go = g;
    abort = a;
    @(posedge clock);
    #1;
    hit = 1'b0;
    go = 1'b0;
    abort = 1'b0;
  endtask

  task automatic push(input bit game, input bit win,
                      input int hits, input int idx);
    exp_t e;
    e.game = game;
    e.win = win;
    e.score = exp_score;
    e.hits = hits;
    e.idx = idx;
    e.werr = exp_werr;
    e.due = cyc + 1;
    q.push_back(e);
  endtask

  // Monitor: pops an expectation whenever the DUT reports a round or game end.
  always @(negedge clock) begin
    if (!reset_n) begin
      prev_done <= 1'b0;
    end else begin
      if (round_done) begin
        if (q.size() == 0 || q[0].game) begin
          chk("unexpected_round_done", 1, 0);
        end else begin
          m = q.pop_front();
          chk("rd_time", cyc, m.due);
          chk("rd_win", int'(round_win), int'(m.win));
          chk("rd_score", int'(score), m.score);
          chk("rd_hits", int'(hit_cnt), m.hits);
          chk("rd_idx", int'(round_idx), m.idx);
          chk("rd_start_timer", int'(start_timer), 0);
          chk("rd_busy", int'(busy), 1);
          chk("rd_wdog", int'(wdog_err), int'(m.werr));
        end
      end
      if (all_done && !prev_done) begin
        if (q.size() == 0 || !q[0].game) begin
          chk("unexpected_all_done", 1, 0);
        end else begin
          m = q.pop_front();
          chk("gd_time", cyc, m.due);
          chk("gd_score", int'(score), m.score);
          chk("gd_win", int'(round_win), int'(m.win));
          chk("gd_hits", int'(hit_cnt), m.hits);
          chk("gd_idx", int'(round_idx), m.idx);
          chk("gd_busy", int'(busy), 0);
          chk("gd_wdog", int'(wdog_err), int'(m.werr));
        end
      end
      if (q.size() > 0 && q[0].due <= cyc) begin
        chk("missing_event", 0, 1);
        void'(q.pop_front());
      end
      prev_done <= all_done;
    end
  end

  task automatic start_game(input int stale);
    exp_score = 0;
    exp_werr = 1'b0;
    step(rb(), stale > 0, 1'b1, 1'b0);
    chk("arm_start_timer", int'(start_timer), 0);
    chk("arm_busy", int'(busy), 1);
    chk("arm_all_done", int'(all_done), 0);
    chk("arm_hit_clr", int'(hit_cnt), 0);
    chk("arm_score_clr", int'(score), 0);
    chk("arm_win_clr", int'(round_win), 0);
    for (int i = 1; i < stale; i++) begin
      step(rb(), 1'b1, 1'b0, 1'b0);
      chk("stale_hold", int'(start_timer), 0);
    end
    step(rb(), 1'b0, 1'b0, 1'b0);
    chk("run_start_timer", int'(start_timer), 1);
  endtask

  // Round outcome from the rules: win when the TARGET-th hit lands at or
  // before the first RUN edge seeing timesup, otherwise loss at that edge.
  task automatic play_round(input int ridx, input int mode,
                            input bit last,
                            output int hits_o, output bit win_o);
    int cnt;
    int d;
    int pct;
    int k;
    int r;
    bit ts;
    bit h;
    bit dec;
    bit win;
    cnt = 0;
    k = 0;
    ts = 1'b0;
    dec = 1'b0;
    win = 1'b0;
    case (mode)
      0: begin pct = 0; d = 60; end
      1: begin pct = 100; d = TARGET; end
      2: begin
        pct = int'($urandom_range(15, 80));
        d = int'($urandom_range(3, 45));
      end
      default: begin pct = 0; d = 100000; end
    endcase
    while (!dec) begin
      k++;
      h = (int'($urandom_range(0, 99)) < pct);
      ts = (k >= d);
      if (h) cnt++;
      if (cnt == TARGET) begin
        dec = 1'b1;
        win = 1'b1;
        exp_score++;
      end else if (ts) begin
        dec = 1'b1;
      end
`ifdef TIMER_CTRL_WDOG_EN
      else if (k == WDOG) begin
        dec = 1'b1;
        exp_werr = 1'b1;
      end
`endif
      if (dec) push(1'b0, win, cnt, ridx);
      step(h, ts, rgo(), 1'b0);
    end
    chk("rel_start_timer", int'(start_timer), 0);
    r = ts ? int'($urandom_range(0, 3)) : 0;
    for (int i = 0; i < r; i++) step(rb(), 1'b1, rgo(), 1'b0);
    if (last) push(1'b1, win, cnt, ridx);
    step(rb(), 1'b0, rgo(), 1'b0);
    if (!last) begin
      step(rb(), 1'b0, rgo(), 1'b0);
      chk("next_start_timer", int'(start_timer), 1);
      chk("next_hit_clr", int'(hit_cnt), 0);
      chk("next_idx", int'(round_idx), ridx + 1);
    end
    hits_o = cnt;
    win_o = win;
  endtask

  task automatic play_game(input int stale, input int m0,
                           input int m1, input int m2);
    int hits;
    bit win;
    start_game(stale);
    play_round(0, m0, 1'b0, hits, win);
    play_round(1, m1, 1'b0, hits, win);
    play_round(2, m2, 1'b1, hits, win);
    step(1'b1, 1'b0, 1'b0, 1'b0);
    step(rb(), 1'b0, 1'b0, 1'b0);
    chk("done_hold_hits", int'(hit_cnt), hits);
    chk("done_hold_score", int'(score), exp_score);
    chk("done_level", int'(all_done), 1);
  endtask

  task automatic rnd_mode(output int md);
    md = int'($urandom_range(0, 5));
    md = (md == 0) ? 0 : ((md < 3) ? 1 : 2);
  endtask

  initial begin
    int hits;
    bit win;
    int m0;
    int m1;
    int m2;
    #1;
    step(1'b0, 1'b0, 1'b0, 1'b0);
    chk("rst_start_timer", int'(start_timer), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_idx", int'(round_idx), 0);
    chk("rst_hits", int'(hit_cnt), 0);
    chk("rst_score", int'(score), 0);
    chk("rst_round_done", int'(round_done), 0);
    chk("rst_win", int'(round_win), 0);
    chk("rst_all_done", int'(all_done), 0);
    chk("rst_wdog", int'(wdog_err), 0);
    reset_n = 1'b1;
    step(1'b1, 1'b0, 1'b0, 1'b0);
    chk("idle_hit_ignored", int'(hit_cnt), 0);

    play_game(0, 0, 0, 0);
    play_game(3, 2, 1, 2);
    for (int g = 0; g < 8; g++) begin
      rnd_mode(m0);
      rnd_mode(m1);
      rnd_mode(m2);
      play_game((g % 2 == 0) ? 0 : 3, m0, m1, m2);
    end
`ifdef TIMER_CTRL_WDOG_EN
    play_game(0, 3, 2, 3);
`endif

    start_game(0);
    play_round(0, 1, 1'b0, hits, win);
    repeat (5) step(1'b1, 1'b0, 1'b0, 1'b0);
    chk("pre_abort_hits", int'(hit_cnt), 5);
    step(1'b0, 1'b0, 1'b1, 1'b0);
    chk("go_in_run_hits", int'(hit_cnt), 5);
    chk("go_in_run_idx", int'(round_idx), 1);
    chk("go_in_run_timer", int'(start_timer), 1);
    step(1'b1, 1'b0, 1'b1, 1'b1);
    chk("abort_timer", int'(start_timer), 0);
    chk("abort_hits", int'(hit_cnt), 0);
    chk("abort_busy", int'(busy), 0);
    chk("abort_score", int'(score), 0);
    chk("abort_idx", int'(round_idx), 0);
    step(1'b1, 1'b0, 1'b0, 1'b0);
    chk("abort_idle_busy", int'(busy), 0);

    start_game(0);
    repeat (3) step(1'b1, 1'b0, 1'b0, 1'b0);
    reset_n = 1'b0;
    #1;
    chk("async_rst_timer", int'(start_timer), 0);
    chk("async_rst_hits", int'(hit_cnt), 0);
    chk("async_rst_busy", int'(busy), 0);
    step(1'b0, 1'b0, 1'b0, 1'b0);
    reset_n = 1'b1;
    repeat (3) step(1'b0, 1'b0, 1'b0, 1'b0);
    chk("queue_drained", q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
